// File: rtl/tlp_fifo_arb.sv
// tlp_fifo_arb: packet-granular arbiter merging two FWFT captured-TLP FIFOs into one read port
// Ports: clk156, sys_rst_n (synchronous, active-low); rd_en0/dout0/empty0 and rd_en1/dout1/empty1
// face the two source FIFOs; rd_en/dout/empty form the merged FIFO port; dir is the granted source;
// pkt_cnt0/pkt_cnt1 count forwarded packets per source.
// Entry layout: [73:66] tkeep, [65:2] data, [1] last, [0] user.
// Define TLP_ARB_STATS_EN to build the packet counters; without it both counters read 0.
module tlp_fifo_arb #(
  parameter logic fixed_prio = 1'b0,
  parameter int   cnt_width  = 32
) (
  input  logic                 clk156,
  input  logic                 sys_rst_n,
  output logic                 rd_en0,
  input  logic [73:0]          dout0,
  input  logic                 empty0,
  output logic                 rd_en1,
  input  logic [73:0]          dout1,
  input  logic                 empty1,
  input  logic                 rd_en,
  output logic [73:0]          dout,
  output logic                 empty,
  output logic                 dir,
  output logic [cnt_width-1:0] pkt_cnt0,
  output logic [cnt_width-1:0] pkt_cnt1
);
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_GNT0 = 2'd1;
  localparam logic [1:0] ARB_GNT1 = 2'd2;
  logic [1:0] state_q, state_d;
  logic       last_gnt_q, last_gnt_d, dir_q, dir_d;
  logic       busy, gnt1, any, pick, src_empty, accept, done;
  always_comb begin
    busy = state_q != ARB_IDLE;
    gnt1 = state_q == ARB_GNT1;
    any = ~empty0 | ~empty1;
    // With both sources waiting, round-robin serves the one not granted last.
    pick = (~empty0 & ~empty1) ? (fixed_prio ? 1'b0 : ~last_gnt_q) : empty0;
    src_empty = gnt1 ? empty1 : empty0;
    // Reads into an empty source or while in reset never reach the FIFOs.
    accept = sys_rst_n & busy & rd_en & ~src_empty;
    dout = gnt1 ? dout1 : dout0;
    done = accept & dout[1];
    empty = ~busy | src_empty;
    rd_en0 = accept & ~gnt1;
    rd_en1 = accept & gnt1;
    state_d = ~busy ? (any ? (pick ? ARB_GNT1 : ARB_GNT0) : ARB_IDLE) : (done ? ARB_IDLE : state_q);
    last_gnt_d = done ? gnt1 : last_gnt_q;
    dir_d = (~busy & any) ? pick : dir_q;
  end
  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      state_q <= ARB_IDLE;
      last_gnt_q <= 1'b1;
      dir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_gnt_q <= last_gnt_d;
      dir_q <= dir_d;
    end
  end
  assign dir = dir_q;
`ifdef TLP_ARB_STATS_EN
  logic [cnt_width-1:0] cnt0_q, cnt1_q;
  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_q + cnt_width'(done & ~gnt1);
      cnt1_q <= cnt1_q + cnt_width'(done & gnt1);
    end
  end
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
`else
  assign pkt_cnt0 = '0;
  assign pkt_cnt1 = '0;
`endif
endmodule
